core_ctrl_fsm: RTL

CORE_CTRL_FSM -- requirements
Module: core_ctrl_fsm

---
 rtl/core_ctrl_pkg.sv | 15 +
 rtl/core_ctrl_fsm.sv | 110 +++++++++++
 2 files changed

// File: rtl/core_ctrl_pkg.sv
// core_ctrl_pkg: shared state, instruction-type, pc_src and wb_sel encodings
package core_ctrl_pkg;
    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEM       = 3'd3,
        S_WRITEBACK = 3'd4,
        S_HALT      = 3'd5
    } state_t;
    localparam logic [2:0] T_UNK = 3'd0, T_R = 3'd1, T_I = 3'd2, T_S = 3'd3;
    localparam logic [2:0] T_B = 3'd4, T_U = 3'd5, T_J = 3'd6, T_SYS = 3'd7;
    localparam logic [1:0] PC_PLUS4 = 2'd0, PC_TARGET = 2'd1, PC_HOLD = 2'd2;
    localparam logic [1:0] WB_ALU = 2'd0, WB_LOAD = 2'd1, WB_PC4 = 2'd2;
endpackage

// File: rtl/core_ctrl_fsm.sv
// core_ctrl_fsm: multi-cycle core controller with memory-wait timeout and retire counter
module core_ctrl_fsm
    import core_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  instr_type,
    input  logic        is_load,
    input  logic        br_taken,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_src,
    output logic        alu_src_b,
    output logic        rf_we,
    output logic [1:0]  wb_sel,
    output logic        halted,
    output logic        fault,
    output logic [2:0]  state,
    output logic [31:0] instret
);
    localparam int WW = $clog2(MEM_TIMEOUT + 1);

    state_t      st, nxt;
    logic [WW-1:0] wait_cnt;
    logic [2:0]  lt_type;
    logic        lt_load, set_fault, timeout;

    assign state  = st;
    assign halted = st == S_HALT;

    // Outputs are gated off while rst is high so nothing escapes during the reset cycle
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pc_src    = PC_HOLD;
        alu_src_b = 1'b0;
        rf_we     = 1'b0;
        wb_sel    = WB_ALU;
        nxt       = st;
        set_fault = 1'b0;
        if (!rst) begin
            case (st)
                S_FETCH: begin
                    mem_req = 1'b1;
                    ir_we   = mem_ready;
                    nxt     = mem_ready ? S_DECODE : S_FETCH;
                end
                S_DECODE: nxt = S_EXECUTE;
                S_EXECUTE: begin
                    alu_src_b = instr_type == T_I || instr_type == T_S;
                    pc_we     = instr_type == T_B;
                    pc_src    = pc_we ? (br_taken ? PC_TARGET : PC_PLUS4) : PC_HOLD;
                    set_fault = instr_type == T_UNK;
                    nxt = (instr_type == T_UNK || instr_type == T_SYS) ? S_HALT
                        : (instr_type == T_B) ? S_FETCH
                        : (instr_type == T_S || (instr_type == T_I && is_load)) ? S_MEM
                        : S_WRITEBACK;
                end
                S_MEM: begin
                    mem_req = 1'b1;
                    mem_we  = lt_type == T_S;
                    pc_we   = mem_ready && lt_type == T_S;
                    pc_src  = pc_we ? PC_PLUS4 : PC_HOLD;
                    nxt     = !mem_ready ? S_MEM : (lt_type == T_S) ? S_FETCH : S_WRITEBACK;
                end
                S_WRITEBACK: begin
                    rf_we  = 1'b1;
                    pc_we  = 1'b1;
                    wb_sel = lt_load ? WB_LOAD : (lt_type == T_J) ? WB_PC4 : WB_ALU;
                    pc_src = (lt_type == T_J) ? PC_TARGET : PC_PLUS4;
                    nxt    = S_FETCH;
                end
                default: nxt = S_HALT;
            endcase
        end
        timeout = mem_req && !mem_ready && wait_cnt == WW'(MEM_TIMEOUT - 1);
        if (timeout) begin
            nxt       = S_HALT;
            set_fault = 1'b1;
        end
    end

    // Every retirement coincides with a PC update, so pc_we drives instret
    always_ff @(posedge clk) begin
        if (rst) begin
            st       <= S_FETCH;
            instret  <= '0;
            fault    <= 1'b0;
            wait_cnt <= '0;
            lt_type  <= T_UNK;
            lt_load  <= 1'b0;
        end else begin
            st       <= nxt;
            instret  <= instret + 32'(pc_we);
            fault    <= fault | set_fault;
            wait_cnt <= (mem_req && !mem_ready) ? wait_cnt + 1'b1 : '0;
            if (st == S_EXECUTE) begin
                lt_type <= instr_type;
                lt_load <= instr_type == T_I && is_load;
            end
        end
    end
endmodule
